// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite SRAM slave: response codes, FSM state
// types and the read-delay LFSR seed/step used when AXIL_SRAM_RAND_DELAY_EN is set.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR (shift left, feedback into bit 0).
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/axil_sram_array.sv
// Byte-masked word storage: one synchronous write port with per-byte enables and
// one combinational read port. Built as four byte-lane arrays so each lane keeps
// its own write enable. Contents are never reset.
module axil_sram_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [3:0]                     i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  logic [31:0]                    i_wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
    output logic [31:0]                    o_rdata
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];

        // Write this byte lane when the commit enables it.
        always_ff @(posedge clk) begin
            if (i_we && i_be[gi]) begin
                r_mem[i_waddr] <= i_wdata[8*gi +: 8];
            end
        end

        assign o_rdata[8*gi +: 8] = r_mem[i_raddr];
    end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave in front of a byte-masked SRAM. Independent read and write
// FSMs; reads complete a fixed number of cycles after the AR handshake.
// Optional feature macro: AXIL_SRAM_RAND_DELAY_EN adds 0..3 extra read-latency
// cycles drawn from an 8-bit LFSR at each AR handshake.
module axil_sram_slave
    import axil_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 5;

    // Read side state
    rd_state_t        r_rstate;
    logic             r_arready;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;
    logic [31:2]      r_araddr;
    logic [CNT_W-1:0] r_cnt;

    // Write side state
    wr_state_t        r_wstate;
    logic             r_awready;
    logic             r_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic             r_aw_latched;
    logic             r_w_latched;
    logic [31:2]      r_awaddr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;

    logic             w_ar_hs;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_aw_have;
    logic             w_w_have;
    logic [31:2]      w_wr_addr;
    logic [31:0]      w_wr_data;
    logic [3:0]       w_wr_strb;
    logic             w_wr_oor;
    logic             w_commit;
    logic             w_rd_oor;
    logic [31:0]      w_rd_word;
    logic [CNT_W-1:0] w_extra;
    logic             w_unused_addr_lsbs;

    // Byte offsets within a word are the master's concern.
    assign w_unused_addr_lsbs = &{1'b0, araddr[1:0], awaddr[1:0]};

    assign w_ar_hs = arvalid && r_arready;
    assign w_aw_hs = awvalid && r_awready;
    assign w_w_hs  = wvalid  && r_wready;

    // The second half of a write may arrive on the bus in the commit cycle, so
    // the commit takes address/data from the bus unless already latched.
    assign w_aw_have = r_aw_latched || w_aw_hs;
    assign w_w_have  = r_w_latched  || w_w_hs;
    assign w_wr_addr = r_aw_latched ? r_awaddr : awaddr[31:2];
    assign w_wr_data = r_w_latched  ? r_wdata  : wdata;
    assign w_wr_strb = r_w_latched  ? r_wstrb  : wstrb;
    assign w_wr_oor  = |w_wr_addr[31:AW+2];
    assign w_commit  = (r_wstate == W_IDLE) && w_aw_have && w_w_have && !rst;

    assign w_rd_oor  = |r_araddr[31:AW+2];

`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;

    // Free-running delay LFSR, reseeded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign w_extra = {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};
`else
    assign w_extra = '0;
`endif

    axil_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit && !w_wr_oor),
        .i_be    (w_wr_strb),
        .i_waddr (w_wr_addr[AW+1:2]),
        .i_wdata (w_wr_data),
        .i_raddr (r_araddr[AW+1:2]),
        .o_rdata (w_rd_word)
    );

    // Read FSM: accept AR, count down the latency, present data until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_araddr  <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr  <= araddr[31:2];
                        r_cnt     <= CNT_W'(RD_LAT - 1) + w_extra;
                        r_arready <= 1'b0;
                        r_rstate  <= R_WAIT;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == '0) begin
                        // Array read is combinational, so a same-cycle write
                        // commit is not yet visible here: old data is returned.
                        r_rdata  <= w_rd_oor ? 32'h0 : w_rd_word;
                        r_rresp  <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Write FSM: latch AW and W independently, commit when both are held, then
    // hold the response until bready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate     <= W_IDLE;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr <= awaddr[31:2];
                    end
                    if (w_w_hs) begin
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                    end
                    r_aw_latched <= w_aw_have;
                    r_w_latched  <= w_w_have;
                    if (w_aw_have && w_w_have) begin
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_RESP;
                    end else begin
                        r_awready <= !w_aw_have;
                        r_wready  <= !w_w_have;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid     <= 1'b0;
                        r_aw_latched <= 1'b0;
                        r_w_latched  <= 1'b0;
                        r_awready    <= 1'b1;
                        r_wready     <= 1'b1;
                        r_wstate     <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                    r_bvalid <= 1'b0;
                end
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave (default build, RD_LAT=3, 1024 words).
// Expected read/write responses are queued at issue and checked on completion.
module tb_axil_sram_slave;

    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    always #5 clk = ~clk;

    axil_sram_slave #(
        .DEPTH_WORDS(1024),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [1:0]  wr_q[$];
    logic [31:0] model [int];
    int          total = 0;
    int          bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return a[31:12] != 20'h0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int idx;
        idx = int'(a[11:2]);
        if (is_oor(a)) return 32'h0;
        if (model.exists(idx)) return model[idx];
        return 32'h0;
    endfunction

    // Queue the expected response and apply the byte-masked update to the model.
    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        logic [31:0] cur;
        idx = int'(a[11:2]);
        wr_q.push_back(is_oor(a) ? 2'b10 : 2'b00);
        if (!is_oor(a)) begin
            cur = model_rd(a);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
            end
            model[idx] = cur;
        end
    endtask

    task automatic expect_read(input logic [31:0] a);
        rd_exp_t e;
        e.data = model_rd(a);
        e.resp = is_oor(a) ? 2'b10 : 2'b00;
        rd_q.push_back(e);
    endtask

    task automatic collect_b(input string tag);
        int n;
        logic [1:0] e;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_bvalid_seen"}, 32'(bvalid), 32'd1);
        if (bvalid) begin
            if (wr_q.size() == 0) begin
                check({tag, "_bq_nonempty"}, 32'(wr_q.size()), 32'd1);
            end else begin
                e = wr_q.pop_front();
                check({tag, "_bresp"}, 32'(bresp), 32'(e));
                $display("write %s: bresp=%0d", tag, bresp);
            end
        end
        tick();
        bready = 1'b0;
    endtask

    task automatic collect_r(input string tag);
        int n;
        rd_exp_t e;
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_rvalid_seen"}, 32'(rvalid), 32'd1);
        if (rvalid) begin
            if (rd_q.size() == 0) begin
                check({tag, "_rq_nonempty"}, 32'(rd_q.size()), 32'd1);
            end else begin
                e = rd_q.pop_front();
                check({tag, "_rdata"}, rdata, e.data);
                check({tag, "_rresp"}, 32'(rresp), 32'(e.resp));
                $display("read %s: rdata=%h rresp=%0d", tag, rdata, rresp);
            end
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bit aw_done;
        bit w_done;
        bit aw_hs;
        bit w_hs;
        int n;
        expect_write(a, d, s);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            n++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check({tag, "_accepted"}, 32'(aw_done && w_done), 32'd1);
        collect_b(tag);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a);
        int n;
        expect_read(a);
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(RD_LAT));
        collect_r(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_wready",  32'(wready),  32'd1);

        // AW+W same cycle, then read back with latency check
        do_write("w10", 32'h10, 32'hDEADBEEF, 4'hF);
        do_read("r10", 32'h10);

        // Partial byte strobes over a preload
        do_write("w20_pre", 32'h20, 32'h11223344, 4'hF);
        do_write("w20_strb", 32'h20, 32'hAABBCCDD, 4'b0101);
        do_read("r20", 32'h20);

        // Zero strobe: OKAY, no change
        do_write("w20_zero", 32'h20, 32'hFFFFFFFF, 4'b0000);
        do_read("r20_zero", 32'h20);

        // W five cycles ahead of AW, then bready stalled
        expect_write(32'h40, 32'hCAFE0040, 4'hF);
        wdata  = 32'hCAFE0040;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wfirst_wready_low",  32'(wready),  32'd0);
            check("wfirst_awready_hi",  32'(awready), 32'd1);
            check("wfirst_bvalid_low",  32'(bvalid),  32'd0);
            tick();
        end
        awaddr  = 32'h40;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_bvalid_on_aw", 32'(bvalid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bstall_bvalid",  32'(bvalid),  32'd1);
            check("bstall_awready", 32'(awready), 32'd0);
        end
        collect_b("w40");
        do_read("r40", 32'h40);

        // Out of range read and write; word 0 alias must stay intact
        do_write("w00", 32'h0, 32'h0BADF00D, 4'hF);
        do_read("r_oor", 32'h0000_1000);
        do_write("w_oor", 32'h0000_1000, 32'h12345678, 4'hF);
        do_read("r00", 32'h0);

        // Reset while the read is counting down
        araddr  = 32'h10;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_rvalid_a", 32'(rvalid), 32'd0);
        tick();
        rst = 1'b0;
        check("rstmid_rvalid_b", 32'(rvalid), 32'd0);
        tick();
        check("rstmid_arready", 32'(arready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("rstmid_rvalid_quiet", 32'(rvalid), 32'd0);
            tick();
        end
        do_read("r10_after_rst", 32'h10);

        // Read sample and write commit to the same word in one cycle
        do_write("w30_pre", 32'h30, 32'h1, 4'hF);
        expect_read(32'h30);
        araddr  = 32'h30;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        tick();
        expect_write(32'h30, 32'h2, 4'hF);
        awaddr  = 32'h30;
        wdata   = 32'h2;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("collide_rvalid", 32'(rvalid), 32'd1);
        check("collide_bvalid", 32'(bvalid), 32'd1);
        collect_r("r30_collide");
        collect_b("w30_collide");
        do_read("r30_new", 32'h30);

        check("rq_drained", 32'(rd_q.size()), 32'd0);
        check("bq_drained", 32'(wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_sram_slave.md
AXIL_SRAM_SLAVE -- requirements
Module: axil_sram_slave

Interface
REQ-001 SHALL take parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two).
REQ-002 SHALL take parameter RD_LAT, default 3, cycles from AR handshake to rvalid (range 1..15).
REQ-003 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-005 SHALL have ports araddr in 32, arvalid in 1, arready out 1: read address channel.
REQ-006 SHALL have ports rdata out 32, rresp out 2, rvalid out 1, rready in 1: read data channel.
REQ-007 SHALL have ports awaddr in 32, awvalid in 1, awready out 1: write address channel.
REQ-008 SHALL have ports wdata in 32, wstrb in 4, wvalid in 1, wready out 1: write data channel.
REQ-009 SHALL have ports bresp out 2, bvalid out 1, bready in 1: write response channel.

Function
REQ-010 SHALL use read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
- arready=1 only in R_IDLE.
- AR handshake latches araddr and loads the latency counter.
REQ-011 SHALL decrement the counter in R_WAIT.
- At zero, it samples the array into rdata, asserts rvalid, and enters R_DATA.
- First rvalid comes exactly RD_LAT cycles after the AR handshake.
REQ-012 SHALL hold rvalid, rdata and rresp stable in R_DATA until rready=1, then return to R_IDLE next cycle.
- Only one read is outstanding at a time.
REQ-013 SHALL use write FSM W_IDLE -> W_RESP -> W_IDLE.
- awready=!aw_latched and wready=!w_latched while in W_IDLE.
- AW and W are accepted independently, in either order or in the same cycle.
REQ-014 SHALL commit the write once both AW and W are latched.
- The commit updates only the bytes whose wstrb bit is 1.
- In the same cycle it asserts bvalid and enters W_RESP.
- In W_RESP, awready=wready=0.
REQ-015 SHALL hold bvalid until bready=1, then clear both latches and return to W_IDLE.
REQ-016 SHALL form the word index from addr[log2(DEPTH_WORDS)+1:2] and ignore addr[1:0].
- Sub-word alignment is the master's job via wstrb and read shifting.
REQ-017 SHALL treat an address with any bit set at or above log2(DEPTH_WORDS)+2 as out of range.
- Out-of-range reads return rdata=0 with rresp=2'b10.
- Out-of-range writes leave the array unchanged and return bresp=2'b10.
- In-range accesses return resp 2'b00.
REQ-018 SHALL return the pre-write data when a read sample and a write commit to the same word fall in the same cycle.
REQ-019 SHALL accept wstrb=4'b0000 with no array change and bresp=2'b00.
REQ-020 SHALL let the read and write FSMs run fully concurrently, with no mutual stalls.

Reset
REQ-021 SHALL clear these on rst: arready, rvalid, awready, wready, bvalid, rdata, rresp, bresp, both latches and the counter.
- The FSMs go to R_IDLE and W_IDLE.
REQ-022 SHALL raise arready, awready and wready in the first cycle after rst deasserts.
REQ-023 SHALL preserve array contents across rst.
- A reset mid-transaction abandons that transaction with no partial write.

Configuration
REQ-024 SHALL, with AXIL_SRAM_RAND_DELAY_EN defined, add extra read latency lfsr[1:0] (0..3) per transaction.
- The LFSR is 8-bit, x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst, and advances every cycle.
- The extra latency is sampled at the AR handshake.
REQ-025 SHALL, without AXIL_SRAM_RAND_DELAY_EN, have a fixed read latency of exactly RD_LAT and no LFSR logic.

Structure
REQ-026 SHALL put these in shared package axil_pkg:
- resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
- read and write FSM state typedefs;
- the LFSR seed constant.
REQ-027 SHALL implement the byte-masked storage as sub-module axil_sram_array:
- one synchronous write port with 4-bit byte enable;
- one combinational read port.

Verification (AXIL_SRAM_RAND_DELAY_EN undefined, RD_LAT=3)
REQ-028 SHALL cover: AW and W in the same cycle to 0x10, wdata 32'hDEADBEEF, wstrb 4'hF, then AR to 0x10 -> bresp 0, then rvalid exactly 3 cycles after the AR handshake with rdata 32'hDEADBEEF, rresp 0.
REQ-029 SHALL cover: W 12'h... preload 32'h11223344 at 0x20, then write wdata 32'hAABBCCDD, wstrb 4'b0101 -> read returns 32'h11BB33DD.
REQ-030 SHALL cover: W issued 5 cycles before AW -> wready drops after W accepted, bvalid arrives in the cycle AW is accepted, and bready held 0 for 4 cycles keeps bvalid=1 and awready=0.
REQ-031 SHALL cover: AR to 32'h0000_1000 (DEPTH_WORDS=1024) -> rdata 0 and rresp 2'b10; a write there -> bresp 2'b10 and array unchanged.
REQ-032 SHALL cover: rst asserted while in R_WAIT with rready=0 -> rvalid never rises, arready=1 one cycle after rst drops, and previously written data still reads back.
REQ-033 SHALL cover: read sample and write commit to 0x30 in the same cycle (old 32'h1, new 32'h2) -> rdata=32'h1, and a subsequent read returns 32'h2.
